// File: rtl/alu_arb_pkg.sv
// Shared constants for the two-requester ALU arbiter:
// FSM state codes, requester ids and ALU opcode encoding.
package alu_arb_pkg;

    localparam int SEL_W = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam logic [SEL_W-1:0] OP_ADD = 3'b000;
    localparam logic [SEL_W-1:0] OP_SUB = 3'b001;
    localparam logic [SEL_W-1:0] OP_AND = 3'b010;
    localparam logic [SEL_W-1:0] OP_OR  = 3'b011;
    localparam logic [SEL_W-1:0] OP_XOR = 3'b100;
    localparam logic [SEL_W-1:0] OP_SHL = 3'b101;
    localparam logic [SEL_W-1:0] OP_SHR = 3'b110;
    localparam logic [SEL_W-1:0] OP_SLT = 3'b111;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared combinational ALU: WIDTH-bit result that wraps on overflow,
// plus a Zero flag. SLT is an unsigned compare producing 0 or 1.
module alu_arbiter_alu
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [SEL_W-1:0] i_sel,
    output logic [WIDTH-1:0] o_out,
    output logic             o_zero
);

    // Opcode decode into the result bus
    always_comb begin
        o_out = '0;
        case (i_sel)
            OP_ADD:  o_out = i_a + i_b;
            OP_SUB:  o_out = i_a - i_b;
            OP_AND:  o_out = i_a & i_b;
            OP_OR:   o_out = i_a | i_b;
            OP_XOR:  o_out = i_a ^ i_b;
            OP_SHL:  o_out = i_a << 1;
            OP_SHR:  o_out = i_a >> 1;
            OP_SLT:  o_out = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
            default: o_out = '0;
        endcase
    end

    assign o_zero = (o_out == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// IDLE grants and latches, EXEC registers the result, RESP waits for consume.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic [SEL_W-1:0] req1_sel,
    output logic             resp0_valid,
    output logic             resp1_valid,
    input  logic             resp0_ready,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             busy
);

    logic [1:0]       r_state;
    logic             r_last;
    logic             r_id;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [SEL_W-1:0] r_sel;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic             w_gnt_id;
    logic             w_accept;
    logic             w_resp_hs;
    logic [WIDTH-1:0] w_alu_out;
    logic             w_alu_zero;

    // Round-robin pick: on a tie favour whoever was not served last
    always_comb begin
        w_gnt_id = REQ0;
        if (req0_valid && req1_valid) begin
            w_gnt_id = ~r_last;
        end else if (req1_valid) begin
            w_gnt_id = REQ1;
        end
    end

    assign w_accept    = !rst && (r_state == ST_IDLE)
                       && (req0_valid || req1_valid);
    assign req0_ready  = w_accept && (w_gnt_id == REQ0);
    assign req1_ready  = w_accept && (w_gnt_id == REQ1);

    assign resp0_valid = (r_state == ST_RESP) && (r_id == REQ0);
    assign resp1_valid = (r_state == ST_RESP) && (r_id == REQ1);
    assign w_resp_hs   = (resp0_valid && resp0_ready)
                       || (resp1_valid && resp1_ready);

    assign busy        = (r_state != ST_IDLE);
    assign resp_result = r_result;
    assign resp_zero   = r_zero;

    alu_arbiter_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_a    (r_a),
        .i_b    (r_b),
        .i_sel  (r_sel),
        .o_out  (w_alu_out),
        .o_zero (w_alu_zero)
    );

    // Control FSM and round-robin pointer (pointer moves only on completion)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_last  <= REQ1;
            r_id    <= REQ0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_id    <= w_gnt_id;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_resp_hs) begin
                        r_last  <= r_id;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Datapath: capture granted operands, then register the ALU outcome
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sel    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= (w_gnt_id == REQ1) ? req1_a : req0_a;
                r_b   <= (w_gnt_id == REQ1) ? req1_b : req0_b;
                r_sel <= (w_gnt_id == REQ1) ? req1_sel : req0_sel;
            end
            if (r_state == ST_EXEC) begin
                r_result <= w_alu_out;
                r_zero   <= w_alu_zero;
            end
        end
    end

endmodule
